// File: rtl/sort_frame_collector.sv
// sort_frame_collector: gathers a serial sample stream into N-wide frames for
// the 6-element sorter. One frame is held at the output while the next one is
// assembled; a short frame (closed early by in_last) is padded with PAD.
module sort_frame_collector #(
  parameter int              DW  = 8,
  parameter int              N   = 6,
  parameter logic [DW-1:0]   PAD = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [N*DW-1:0]   out_data,
  output logic [2:0]        out_count,
  output logic              out_valid,
  input  logic              out_ready
);

  // State registers
  logic [N*DW-1:0] fill_r;
  logic [2:0]      idx_r;
  logic            pending_r;
  logic [2:0]      pend_count_r;
  logic [N*DW-1:0] out_data_r;
  logic [2:0]      out_count_r;
  logic            out_valid_r;
  logic            in_ready_r;

  // Next-state values
  logic [N*DW-1:0] fill_n;
  logic [2:0]      idx_n;
  logic            pending_n;
  logic [2:0]      pend_count_n;
  logic [N*DW-1:0] out_data_n;
  logic [2:0]      out_count_n;
  logic            out_valid_n;

  // Handshake qualifiers and the padded frame as it would look if closed now
  logic            accept_s;
  logic            last_s;
  logic            drain_s;
  logic            out_free_s;
  logic [2:0]      count_s;
  logic [N*DW-1:0] frame_s;

  // in_ready is the registered complement of the next pending state, so it
  // never depends combinationally on out_ready.
  assign accept_s   = in_valid & in_ready_r;
  assign last_s     = accept_s & ((idx_r == 3'(N - 1)) | in_last);
  assign drain_s    = out_valid_r & out_ready;
  assign out_free_s = ~out_valid_r | drain_s;
  assign count_s    = idx_r + 3'd1;

  // Build the closing frame: stored samples below idx, the live sample at idx, PAD above.
  always_comb begin
    frame_s = '0;
    for (int i = 0; i < N; i++) begin
      if (3'(i) < idx_r) begin
        frame_s[i*DW +: DW] = fill_r[i*DW +: DW];
      end else if (3'(i) == idx_r) begin
        frame_s[i*DW +: DW] = in_data;
      end else begin
        frame_s[i*DW +: DW] = PAD;
      end
    end
  end

  // Next-state logic for the fill buffer, the pending slot and the output register.
  always_comb begin
    fill_n       = fill_r;
    idx_n        = idx_r;
    pending_n    = pending_r;
    pend_count_n = pend_count_r;
    out_data_n   = out_data_r;
    out_count_n  = out_count_r;
    out_valid_n  = out_valid_r;
    if (pending_r) begin
      // Input is stalled; the frozen, already padded frame moves out on drain.
      if (drain_s) begin
        out_data_n  = fill_r;
        out_count_n = pend_count_r;
        out_valid_n = 1'b1;
        pending_n   = 1'b0;
      end else begin
        pending_n   = 1'b1;
      end
    end else begin
      if (drain_s) begin
        out_valid_n = 1'b0;
      end else begin
        out_valid_n = out_valid_r;
      end
      if (last_s) begin
        idx_n = 3'd0;
        if (out_free_s) begin
          out_data_n  = frame_s;
          out_count_n = count_s;
          out_valid_n = 1'b1;
        end else begin
          // Park the padded frame in the fill buffer until the output drains.
          fill_n       = frame_s;
          pend_count_n = count_s;
          pending_n    = 1'b1;
        end
      end else if (accept_s) begin
        fill_n[DW*idx_r +: DW] = in_data;
        idx_n                  = idx_r + 3'd1;
      end else begin
        idx_n = idx_r;
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_r       <= '0;
      idx_r        <= 3'd0;
      pending_r    <= 1'b0;
      pend_count_r <= 3'd0;
      out_data_r   <= '0;
      out_count_r  <= 3'd0;
      out_valid_r  <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      fill_r       <= fill_n;
      idx_r        <= idx_n;
      pending_r    <= pending_n;
      pend_count_r <= pend_count_n;
      out_data_r   <= out_data_n;
      out_count_r  <= out_count_n;
      out_valid_r  <= out_valid_n;
      in_ready_r   <= ~pending_n;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_data  = out_data_r;
  assign out_count = out_count_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_sort_frame_collector.sv
// Testbench for sort_frame_collector: a bench-side frame model pushes expected
// frames to a scoreboard as samples are accepted; a monitor pops and compares
// each frame as the DUT hands it over.
module tb_sort_frame_collector;

  localparam int            DW  = 8;
  localparam int            N   = 6;
  localparam logic [DW-1:0] PAD = 8'hFF;

  typedef struct {
    logic [N*DW-1:0] data;
    logic [2:0]      count;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [DW-1:0]   in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] out_data;
  logic [2:0]      out_count;
  logic            out_valid;
  logic            out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t          sb[$];
  logic [DW-1:0] cur[$];

  sort_frame_collector #(.DW(DW), .N(N), .PAD(PAD)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_count(out_count),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: a frame transfers at the next rising edge
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got data=%h count=%0d, expected no frame", out_data, out_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_data !== e.data || out_count !== e.count) begin
          errors++;
          $display("FAIL sb_frame: got data=%h count=%0d, expected data=%h count=%0d",
                   out_data, out_count, e.data, e.count);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and hold it until accepted; updates the frame model.
  task automatic send(input logic [DW-1:0] d, input logic last);
    logic acc;
    int   guard;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    guard    = 0;
    acc      = 1'b0;
    while (!acc && guard < 200) begin
      acc = in_ready;
      step();
      guard++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected acceptance of %h", d);
    end else begin
      cur.push_back(d);
      if (cur.size() == N || last) begin
        exp_t e;
        e.count = 3'(cur.size());
        for (int i = 0; i < N; i++) begin
          e.data[i*DW +: DW] = (i < cur.size()) ? cur[i] : PAD;
        end
        sb.push_back(e);
        cur.delete();
      end
    end
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (cycles) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h, expected 0", out_data); end
    if (out_count !== 3'd0) begin errors++; $display("FAIL reset_out_count: got %0d, expected 0", out_count); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_full_frame();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) send(8'h10 + 8'(i), 1'b0);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL full_latency: got out_valid=%b, expected 1", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL full_one_cycle: got out_valid=%b, expected 0", out_valid); end
    idle(2);
  endtask

  task automatic test_short_frame();
    out_ready = 1'b1;
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b1);
    send(8'h07, 1'b1);
    idle(3);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 2*N; i++) send(8'(i), 1'b0);
    in_valid = 1'b0;
    checks += 2;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b, expected 0", in_ready); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_held: got out_valid=%b, expected 1", out_valid); end
    idle(3);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_stays_low: got %b, expected 0", in_ready); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_reload_valid: got %b, expected 1", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back: got %b, expected 1", in_ready); end
    if (out_data !== 48'h0B0A_0908_0706) begin
      errors++; $display("FAIL bp_frame2: got %h, expected 0b0a09080706", out_data);
    end
    idle(2);
    out_ready = 1'b1;
    idle(3);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < N + 4; i++) send(8'h40 + 8'(i), 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    cur.delete();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b, expected 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b, expected 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) send(8'h20 + 8'(i), 1'b0);
    idle(3);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 1; k <= 6*N; k++) begin
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: sample %0d got %b, expected 1", k, in_ready); end
      send(8'($urandom_range(0, 255)), 1'b0);
      checks++;
      if (out_valid !== ((k % N) == 0)) begin
        errors++; $display("FAIL stream_spacing: sample %0d got out_valid=%b, expected %b", k, out_valid, (k % N) == 0);
      end
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d undelivered frames, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
